vga_demo_sequencer: RTL and testbench
=====================================

VGA_DEMO_SEQUENCER -- requirements
Module: vga_demo_sequencer

Interface
REQ-001: The block SHALL have parameter V_ACTIVE, default 480, giving the first non-visible line (vblank start).
REQ-002: The block SHALL have parameter DWELL, default 256, giving frames per mode in auto mode (range 2..65535).
REQ-003: The block SHALL have parameter NUM_MODES, default 4, giving the pattern mode count (range 2..4).
REQ-004: The block SHALL have port clk, input, 1, pixel clock, sole clock.
REQ-005: The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006: The block SHALL have port hpos, input, 10, current pixel X from the sync generator.
REQ-007: The block SHALL have port vpos, input, 10, current pixel Y from the sync generator.
REQ-008: The block SHALL have port run, input, 1, level; 1 = animate, 0 = pause.
REQ-009: The block SHALL have port step, input, 1, single-cycle request to advance one frame while paused.
REQ-010: The block SHALL have port manual, input, 1, level; 1 = mode taken from mode_sel.
REQ-011: The block SHALL have port mode_sel, input, 2, requested mode when manual = 1.
REQ-012: The block SHALL have port speed, input, 2, frame increment exponent (increment = 1 << speed).
REQ-013: The block SHALL have port frame_no, output, 9, animation phase fed to the pattern datapath.
REQ-014: The block SHALL have port mode, output, 2, active pattern select.
REQ-015: The block SHALL have port frame_tick, output, 1, one-cycle pulse marking a frame update.
REQ-016: The block SHALL have port mode_changed, output, 1, one-cycle pulse when mode changes.

Function
REQ-017: tick_c SHALL be the combinational condition hpos == 0 and vpos == V_ACTIVE; all state, frame_no and mode updates SHALL occur only on the clk edge where tick_c = 1.
REQ-018: On the tick edge, frame_tick SHALL be registered to 1, and it SHALL be 0 on all other edges. New frame_no and mode SHALL be visible in the same cycle frame_tick is high.
REQ-019: The FSM SHALL have the states PAUSED, RUNNING and STEP_PEND.
REQ-020: In PAUSED, step = 1 SHALL move the FSM to STEP_PEND on any edge, including a tick edge; the advance is taken on the next tick, not the current one.
REQ-021: In PAUSED, at a tick with run = 1, the FSM SHALL go to RUNNING with no advance on that tick.
REQ-022: In RUNNING, at a tick, frame_no SHALL advance by 1 << speed modulo 512.
REQ-023: In RUNNING, at a tick with run = 0, the FSM SHALL go to PAUSED after performing that tick's advance.
REQ-024: In RUNNING, step SHALL be ignored.
REQ-025: In STEP_PEND, at a tick, frame_no SHALL advance by exactly 1 regardless of speed, and the FSM SHALL go to PAUSED, or to RUNNING if run = 1.
REQ-026: In STEP_PEND, a further step SHALL be ignored.
REQ-027: A 16-bit dwell counter SHALL increment on each tick that advances frame_no while manual = 0.
REQ-028: When the dwell counter reaches DWELL-1 and frame_no advances, the dwell counter SHALL wrap to 0 and mode SHALL advance by 1, wrapping from NUM_MODES-1 to 0.
REQ-029: With manual = 1, at every tick in any state, mode SHALL load mode_sel, clamped to NUM_MODES-1 if larger, and the dwell counter SHALL clear to 0.
REQ-030: mode_changed SHALL pulse on the tick edge only if the new mode differs from the old one.
REQ-031: Changes to run, manual, mode_sel or speed between ticks SHALL have no output effect until the next tick.
REQ-032: frame_no arithmetic SHALL be 9-bit unsigned with silent wrap (e.g. 510 + 4 = 2).

Reset
REQ-033: rst_n = 0 SHALL immediately, without a clock, force state to PAUSED, frame_no to 0, mode to 0, dwell counter to 0, frame_tick to 0 and mode_changed to 0.
REQ-034: Reset asserted mid-frame or mid-STEP_PEND SHALL discard any pending step.
REQ-035: After release, the first update SHALL occur at the next tick_c.

Verification
REQ-036: The bench SHALL cover this case: reset, run = 1, speed = 0, 3 ticks -> frame_no = 0, 1, 2 after successive ticks (first tick only enters RUNNING), frame_tick high once per tick.
REQ-037: The bench SHALL cover this case: RUNNING, speed = 3, frame_no = 508, tick -> frame_no = 4.
REQ-038: The bench SHALL cover this case: PAUSED, speed = 2, step pulse on the tick edge -> frame_no unchanged on that tick, +1 on the following tick, FSM back to PAUSED.
REQ-039: The bench SHALL cover this case: DWELL = 4, NUM_MODES = 3, manual = 0, RUNNING for 12 advancing ticks -> mode sequence 0,1,2,0 and mode_changed pulses exactly 3 times.
REQ-040: The bench SHALL cover this case: manual = 1, mode_sel = 3, NUM_MODES = 3 -> mode = 2 at the next tick, mode_changed = 1; same mode_sel on the following tick -> mode_changed = 0.
REQ-041: The bench SHALL cover this case: rst_n low while in STEP_PEND with frame_no = 77 -> asynchronous clear to 0, and the next tick with run = 0 leaves frame_no = 0.

Source files
------------

// File: rtl/vga_demo_sequencer.sv
// vga_demo_sequencer: per-frame animation phase and pattern-mode sequencer for a VGA demo.
// All updates land on the first vblank pixel; run/step/manual select how the frame advances.
module vga_demo_sequencer #(
    parameter int V_ACTIVE  = 480,
    parameter int DWELL     = 256,
    parameter int NUM_MODES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       run,
    input  logic       step,
    input  logic       manual,
    input  logic [1:0] mode_sel,
    input  logic [1:0] speed,
    output logic [8:0] frame_no,
    output logic [1:0] mode,
    output logic       frame_tick,
    output logic       mode_changed
);
    typedef enum logic [1:0] {PAUSED, RUNNING, STEP_PEND} state_t;
    localparam logic [1:0]  MAX_MODE   = 2'(NUM_MODES - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    state_t      state, state_nx;
    logic        tick, adv, wrap;
    logic [8:0]  inc;
    logic [15:0] dwell, dwell_nx;
    logic [1:0]  mode_nx;

    assign tick = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PAUSED;
        else        state <= state_nx;
    end

    // A step seen while paused is latched immediately but only consumed at the next tick
    always_comb begin
        state_nx = state;
        case (state)
            PAUSED:    state_nx = step ? STEP_PEND : (tick && run) ? RUNNING : PAUSED;
            RUNNING:   state_nx = (tick && !run) ? PAUSED : RUNNING;
            STEP_PEND: state_nx = !tick ? STEP_PEND : run ? RUNNING : PAUSED;
            default:   state_nx = PAUSED;
        endcase
    end

    always_comb begin
        adv = tick && (state == RUNNING || state == STEP_PEND);
        inc = (state == STEP_PEND) ? 9'd1 : 9'd1 << speed;
    end

    always_comb begin
        wrap     = dwell == DWELL_LAST;
        mode_nx  = manual ? ((mode_sel > MAX_MODE) ? MAX_MODE : mode_sel)
                 : (adv && wrap) ? ((mode == MAX_MODE) ? 2'd0 : mode + 2'd1) : mode;
        dwell_nx = manual ? 16'd0 : adv ? (wrap ? 16'd0 : dwell + 16'd1) : dwell;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_no     <= '0;
            mode         <= '0;
            dwell        <= '0;
            frame_tick   <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            frame_tick   <= tick;
            mode_changed <= tick && (mode_nx != mode);
            if (tick) begin
                frame_no <= adv ? frame_no + inc : frame_no;
                mode     <= mode_nx;
                dwell    <= dwell_nx;
            end
        end
    end
endmodule

// File: tb/tb_vga_demo_sequencer.sv
// tb_vga_demo_sequencer: scoreboard bench; each tick pushes its expected frame/mode, popped after the edge.
module tb_vga_demo_sequencer;
    localparam int V = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpos = 10'd5, vpos = 10'd0;
    logic       run = 1'b0, step = 1'b0, manual = 1'b1;
    logic [1:0] mode_sel = 2'd0, speed = 2'd0;
    logic [8:0] frame_no;
    logic [1:0] mode;
    logic       frame_tick, mode_changed;

    typedef struct {logic [8:0] f; logic [1:0] m; logic mc;} exp_t;
    exp_t q[$];
    int vectors = 0, miscompares = 0, mc_count = 0;

    always #5 clk = ~clk;

    vga_demo_sequencer #(.V_ACTIVE(V), .DWELL(4), .NUM_MODES(3)) dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .run(run), .step(step),
        .manual(manual), .mode_sel(mode_sel), .speed(speed), .frame_no(frame_no),
        .mode(mode), .frame_tick(frame_tick), .mode_changed(mode_changed)
    );

    task automatic push(input logic [8:0] f, input logic [1:0] m, input logic mc);
        exp_t e;
        e.f = f; e.m = m; e.mc = mc;
        q.push_back(e);
    endtask

    // Drive one tick cycle (optionally with step), then pop and compare the expected frame update
    task automatic tick(input string name, input logic s);
        exp_t e;
        @(negedge clk); hpos = 10'd0; vpos = 10'(V); step = s;
        @(negedge clk); hpos = 10'd5; vpos = 10'd0; step = 1'b0;
        if (q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = q.pop_front();
        vectors += 4;
        if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL %s frame_tick: got %b want 1", name, frame_tick); end
        if (frame_no !== e.f) begin miscompares++; $display("FAIL %s frame_no: got %0d want %0d", name, frame_no, e.f); end
        if (mode !== e.m) begin miscompares++; $display("FAIL %s mode: got %0d want %0d", name, mode, e.m); end
        if (mode_changed !== e.mc) begin miscompares++; $display("FAIL %s mode_changed: got %b want %b", name, mode_changed, e.mc); end
        if (mode_changed === 1'b1) mc_count++;
        @(negedge clk);
        vectors += 2;
        if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL %s frame_tick_low: got %b want 0", name, frame_tick); end
        if (mode_changed !== 1'b0) begin miscompares++; $display("FAIL %s mode_changed_low: got %b want 0", name, mode_changed); end
    endtask

    task automatic step_pulse();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        vectors += 4;
        if (frame_no !== 9'd0) begin miscompares++; $display("FAIL reset frame_no: got %0d want 0", frame_no); end
        if (mode !== 2'd0) begin miscompares++; $display("FAIL reset mode: got %0d want 0", mode); end
        if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset frame_tick: got %b want 0", frame_tick); end
        if (mode_changed !== 1'b0) begin miscompares++; $display("FAIL reset mode_changed: got %b want 0", mode_changed); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_run_basic();
        run = 1'b1; speed = 2'd0;
        for (int i = 0; i < 3; i++) begin
            push(9'(i), 2'd0, 1'b0);
            tick("run_basic", 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] f = 9'd2;
        speed = 2'd1; f += 9'd2; push(f, 2'd0, 1'b0); tick("speed1", 1'b0);
        speed = 2'd3;
        for (int i = 0; i < 63; i++) begin
            f += 9'd8; push(f, 2'd0, 1'b0); tick("speed3", 1'b0);
        end
        push(9'd4, 2'd0, 1'b0); tick("wrap_508", 1'b0);
        run = 1'b0;
        push(9'd12, 2'd0, 1'b0); tick("pause_advance", 1'b0);
        push(9'd12, 2'd0, 1'b0); tick("paused_hold", 1'b0);
    endtask

    task automatic test_step();
        speed = 2'd2;
        push(9'd12, 2'd0, 1'b0); tick("step_on_tick", 1'b1);
        push(9'd13, 2'd0, 1'b0); tick("step_taken", 1'b0);
        push(9'd13, 2'd0, 1'b0); tick("step_back_paused", 1'b0);
    endtask

    task automatic test_dwell();
        logic [1:0] m = 2'd0;
        do_reset();
        manual = 1'b0; run = 1'b1; speed = 2'd0; mc_count = 0;
        push(9'd0, 2'd0, 1'b0); tick("dwell_enter", 1'b0);
        for (int i = 1; i <= 12; i++) begin
            logic chg = (i % 4) == 0;
            if (chg) m = (m == 2'd2) ? 2'd0 : m + 2'd1;
            push(9'(i), m, chg); tick("dwell", 1'b0);
        end
        vectors++;
        if (mc_count !== 3) begin miscompares++; $display("FAIL dwell_pulses: got %0d want 3", mc_count); end
    endtask

    task automatic test_manual();
        manual = 1'b1; mode_sel = 2'd3;
        push(9'd13, 2'd2, 1'b1); tick("manual_clamp", 1'b0);
        push(9'd14, 2'd2, 1'b0); tick("manual_same", 1'b0);
        mode_sel = 2'd1; speed = 2'd3;
        repeat (3) @(negedge clk);
        vectors += 2;
        if (mode !== 2'd2) begin miscompares++; $display("FAIL between_ticks mode: got %0d want 2", mode); end
        if (frame_no !== 9'd14) begin miscompares++; $display("FAIL between_ticks frame_no: got %0d want 14", frame_no); end
        mode_sel = 2'd0; speed = 2'd0;
        push(9'd15, 2'd0, 1'b1); tick("manual_back0", 1'b0);
    endtask

    task automatic test_reset_step();
        do_reset();
        manual = 1'b1; mode_sel = 2'd0; run = 1'b1; speed = 2'd2;
        push(9'd0, 2'd0, 1'b0); tick("rs_enter", 1'b0);
        for (int i = 1; i <= 18; i++) begin
            push(9'(4 * i), 2'd0, 1'b0); tick("rs_run", 1'b0);
        end
        run = 1'b0;
        push(9'd76, 2'd0, 1'b0); tick("rs_pause", 1'b0);
        step_pulse();
        push(9'd77, 2'd0, 1'b0); tick("rs_step", 1'b0);
        step_pulse();
        @(negedge clk);
        vectors++;
        if (frame_no !== 9'd77) begin miscompares++; $display("FAIL rs_pre frame_no: got %0d want 77", frame_no); end
        #1 rst_n = 1'b0;
        #1;
        vectors += 2;
        if (frame_no !== 9'd0) begin miscompares++; $display("FAIL async_clear frame_no: got %0d want 0", frame_no); end
        if (mode !== 2'd0) begin miscompares++; $display("FAIL async_clear mode: got %0d want 0", mode); end
        @(negedge clk); rst_n = 1'b1;
        push(9'd0, 2'd0, 1'b0); tick("rs_discard", 1'b0);
        push(9'd0, 2'd0, 1'b0); tick("rs_discard2", 1'b0);
    endtask

    initial begin
        test_reset();
        test_run_basic();
        test_wrap();
        test_step();
        test_dwell();
        test_manual();
        test_reset_step();
        vectors++;
        if (q.size() != 0) begin miscompares++; $display("FAIL scoreboard_leftover: got %0d want 0", q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
